// File: rtl/inst_prefetch_pkg.sv
// Shared types and defaults for the instruction prefetch stage.
package inst_prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam int              DEF_DEPTH    = 16;
    localparam int              DEF_ADDR_W   = 16;
    localparam logic [15:0]     DEF_RESET_PC = 16'h0200;
    localparam int              TAKE_MAX     = 3;
    localparam int              BYTE_W       = 8;

endpackage

// File: rtl/inst_prefetch_byte_ring.sv
// Circular byte buffer: one byte written and up to three consumed per cycle,
// with a zero-masked three-byte window starting at the read pointer.
module inst_prefetch_byte_ring
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    wr_en_i,
    input  logic [BYTE_W-1:0]       wr_data_i,
    input  logic                    rd_en_i,
    input  logic [1:0]              rd_len_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [BYTE_W-1:0]       byte0_o,
    output logic [BYTE_W-1:0]       byte1_o,
    output logic [BYTE_W-1:0]       byte2_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  idx1_s, idx2_s;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(rd_len_i);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(wr_en_i)
                    - (rd_en_i ? CNT_W'(rd_len_i) : CNT_W'(0));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the masked window never exposes unwritten slots.
    always_ff @(posedge clk) begin
        if (wr_en_i && !clr_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign idx1_s  = rd_ptr_q + PTR_W'(1);
    assign idx2_s  = rd_ptr_q + PTR_W'(2);
    assign count_o = count_q;

    always_comb begin
        byte0_o = (count_q >= CNT_W'(1)) ? mem_q[rd_ptr_q] : 8'h00;
        byte1_o = (count_q >= CNT_W'(2)) ? mem_q[idx1_s]   : 8'h00;
        byte2_o = (count_q >= CNT_W'(3)) ? mem_q[idx2_s]   : 8'h00;
    end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch: sequential byte fetch into a ring buffer, a three-byte
// decode window with its PC, and flush-driven redirect.
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int                 DEPTH    = DEF_DEPTH,
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    mem_req_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    input  logic [7:0]              mem_rdata_i,
    input  logic                    mem_ack_i,
    input  logic                    flush_i,
    input  logic [ADDR_W-1:0]       flush_pc_i,
    output logic [$clog2(DEPTH):0]  q_count_o,
    output logic [7:0]              q_byte0_o,
    output logic [7:0]              q_byte1_o,
    output logic [7:0]              q_byte2_o,
    output logic [ADDR_W-1:0]       q_pc_o,
    input  logic                    take_i,
    input  logic [1:0]              take_len_i,
    output logic                    take_err_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0]  q_pc_q, q_pc_d;
    logic               mem_req_q, mem_req_d;
    logic               take_err_q, take_err_d;
    logic [CNT_W-1:0]   count_s, count_after_take_s;
    logic               take_ok_s;
    logic               wr_en_s, rd_en_s, clr_s;

    assign take_ok_s = take_i && (take_len_i != 2'd0) && (CNT_W'(take_len_i) <= count_s);
    // The slot reservation: a request goes out only if its byte will fit after this take.
    assign count_after_take_s = take_ok_s ? (count_s - CNT_W'(take_len_i)) : count_s;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        q_pc_d     = q_pc_q;
        take_err_d = 1'b0;
        wr_en_s    = 1'b0;
        rd_en_s    = 1'b0;
        clr_s      = 1'b0;
        if (flush_i) begin
            clr_s      = 1'b1;
            fetch_pc_d = flush_pc_i;
            q_pc_d     = flush_pc_i;
            case (state_q)
                IDLE:    state_d = IDLE;
                BUSY:    state_d = mem_ack_i ? IDLE : DISCARD;
                DISCARD: state_d = mem_ack_i ? IDLE : DISCARD;
                default: state_d = IDLE;
            endcase
        end else begin
            if (take_ok_s) begin
                rd_en_s = 1'b1;
                q_pc_d  = q_pc_q + ADDR_W'(take_len_i);
            end else begin
                take_err_d = take_i;
            end
            case (state_q)
                IDLE: begin
                    if (count_after_take_s < CNT_W'(DEPTH)) begin
                        state_d    = BUSY;
                        mem_addr_d = fetch_pc_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        wr_en_s    = 1'b1;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                        state_d    = IDLE;
                    end else begin
                        state_d = BUSY;
                    end
                end
                DISCARD: state_d = mem_ack_i ? IDLE : DISCARD;
                default: state_d = IDLE;
            endcase
        end
        mem_req_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
            q_pc_q     <= RESET_PC;
            mem_req_q  <= 1'b0;
            take_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            q_pc_q     <= q_pc_d;
            mem_req_q  <= mem_req_d;
            take_err_q <= take_err_d;
        end
    end

    inst_prefetch_byte_ring #(
        .DEPTH (DEPTH)
    ) u_byte_ring (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clr_s),
        .wr_en_i   (wr_en_s),
        .wr_data_i (mem_rdata_i),
        .rd_en_i   (rd_en_s),
        .rd_len_i  (take_len_i),
        .count_o   (count_s),
        .byte0_o   (q_byte0_o),
        .byte1_o   (q_byte1_o),
        .byte2_o   (q_byte2_o)
    );

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign q_count_o  = count_s;
    assign q_pc_o     = q_pc_q;
    assign take_err_o = take_err_q;

endmodule
